// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, fixed-latency unified memory between the IF fetch port
// and the MEM-stage data port. The data port has fixed priority; after STARVE_MAX consecutive
// lost conflicts the fetch port wins the next conflict.
//
// Ports:
//   SYS_clk, SYS_reset          clock (rising edge), asynchronous active-low reset
//   if_req/if_addr              fetch request, held with stable address until if_valid
//   if_gnt/if_valid/if_rdata    fetch issued this cycle, fetch data valid pulse, fetch data
//   dm_req/dm_we/dm_addr/
//   dm_wdata                    data request, held with stable fields until dm_valid
//   dm_gnt/dm_valid/dm_rdata    data issued this cycle, read data / write done pulse, read data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         memory interface; mem_rdata valid MEM_LAT cycles after mem_en
//   stall_if/stall_mem          pipeline freeze while the corresponding port waits
module mem_arbiter #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              SYS_clk,
   input  logic              SYS_reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int unsigned LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   typedef enum logic {StIdle, StBusyRd} state_t;

   state_t              state_q, state_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                owner_dm_q, owner_dm_d;
   logic                if_valid_q, if_valid_d;
   logic                dm_valid_q, dm_valid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

   logic idle;
   logic starved;

   // Gating with SYS_reset forces every combinational output low while reset is held.
   assign idle    = (state_q == StIdle) & SYS_reset;
   assign starved = (starve_q == STARVE_W'(STARVE_MAX));

   assign if_gnt = idle & if_req & (~dm_req | starved);
   assign dm_gnt = idle & dm_req & ~if_gnt;

   assign mem_en    = if_gnt | dm_gnt;
   assign mem_we    = dm_gnt & dm_we;
   assign mem_addr  = if_gnt ? if_addr : (dm_gnt ? dm_addr : '0);
   assign mem_wdata = dm_gnt ? dm_wdata : '0;

   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;

   assign stall_if  = SYS_reset & if_req & ~if_valid_q;
   assign stall_mem = SYS_reset & dm_req & ~dm_valid_q;

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      starve_d   = starve_q;
      owner_dm_d = owner_dm_q;
      if_valid_d = 1'b0;
      dm_valid_d = 1'b0;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;

      unique case (state_q)
         StIdle: begin
            // Only a conflict lost by fetch counts towards starvation.
            if (if_gnt) begin
               starve_d = '0;
            end else if (dm_gnt && if_req && !starved) begin
               starve_d = starve_q + 1'b1;
            end

            if (if_gnt || (dm_gnt && !dm_we)) begin
               owner_dm_d = dm_gnt;
               if (MEM_LAT == 1) begin
                  // Data already valid in the issue cycle: capture at this edge.
                  if (dm_gnt) begin
                     dm_rdata_d = mem_rdata;
                     dm_valid_d = 1'b1;
                  end else begin
                     if_rdata_d = mem_rdata;
                     if_valid_d = 1'b1;
                  end
               end else begin
                  state_d = StBusyRd;
                  lat_d   = LAT_W'(MEM_LAT - 1);
               end
            end else if (dm_gnt) begin
               // Writes complete without occupying the memory past the issue cycle.
               dm_valid_d = 1'b1;
            end
         end

         StBusyRd: begin
            if (lat_q == '0) begin
               state_d = StIdle;
               if (owner_dm_q) begin
                  dm_rdata_d = mem_rdata;
                  dm_valid_d = 1'b1;
               end else begin
                  if_rdata_d = mem_rdata;
                  if_valid_d = 1'b1;
               end
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         state_q    <= StIdle;
         lat_q      <= '0;
         starve_q   <= '0;
         owner_dm_q <= 1'b0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         starve_q   <= starve_d;
         owner_dm_q <= owner_dm_d;
         if_valid_q <= if_valid_d;
         dm_valid_q <= dm_valid_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF fetch port and the MEM-stage data port of the 5-stage pipeline.
- Sequences each access through a fixed-latency memory and returns read data with a valid pulse.
- Produces stall signals that freeze the PC register and the IF/ID or EX/MEM/WB pipeline registers while a port waits.
- Fixed priority goes to the data port, with an anti-starvation override for fetch.

Parameters:
ADDR_W, 8, byte address width (matches the 8-bit PC)
DATA_W, 32, data word width
MEM_LAT, 2, cycles from the memory issue cycle to valid mem_rdata (must be >= 1)
STARVE_MAX, 4, number of consecutive lost conflicts after which IF wins the next conflict

Ports:
SYS_clk  in  1  clock, rising edge
SYS_reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high with stable if_addr until if_valid
if_addr  in  ADDR_W  fetch byte address
if_gnt  out  1  fetch issued to memory this cycle
if_valid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetched instruction
dm_req  in  1  data request; held high with stable addr/we/wdata until dm_valid
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data byte address
dm_wdata  in  DATA_W  write data
dm_gnt  out  1  data access issued this cycle
dm_valid  out  1  one-cycle pulse; read data valid, or write complete
dm_rdata  out  DATA_W  read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
stall_if  out  1  if_req & ~if_valid
stall_mem  out  1  dm_req & ~dm_valid

Behaviour:
- State machine has two states: IDLE and BUSY_RD.
- Issue happens only in IDLE. Grants are combinational in the issue cycle:
  - mem_en = if_gnt | dm_gnt.
  - mem_addr, mem_we and mem_wdata are muxed from the granted port.
  - All mem_* are 0 when nothing is granted.
- Arbitration in IDLE:
  - Only one port requesting: that port is granted.
  - Both requesting: dm is granted, unless starve_cnt == STARVE_MAX, in which case if is granted.
- starve_cnt (saturating):
  - Increments on each conflict that dm wins.
  - Clears on any if grant.
- Read issue (if grant, or dm grant with dm_we=0):
  - Go to BUSY_RD and load lat_cnt = MEM_LAT-1; record the owner (IF or DM).
  - In BUSY_RD, lat_cnt decrements each cycle. No grants are made and mem_en = 0.
  - In the cycle lat_cnt == 0, mem_rdata is valid. At the closing edge it is captured into the owner's rdata register, the owner's valid is set, and state returns to IDLE.
  - When MEM_LAT == 1, the capture happens at the closing edge of the issue cycle itself.
  - Read latency is MEM_LAT+1 cycles from grant to valid.
- Write issue (dm_we=1):
  - mem_we = 1 in the issue cycle.
  - State stays IDLE; dm_valid pulses in the next cycle.
- Valid pulse cycle:
  - The state is IDLE, so a new grant may occur in the same cycle as the valid pulse.
  - The completing requester may drop its req in this cycle or present a new request.
- Requests:
  - A req withdrawn before grant is ignored.
  - A req withdrawn after grant does not cancel the access; valid still pulses.
- Register behaviour:
  - if_rdata and dm_rdata hold their last captured value between accesses.
  - valid outputs are registered single-cycle pulses.
- Reset (SYS_reset = 0, asynchronous):
  - State goes to IDLE; starve_cnt, lat_cnt, both rdata registers and both valids go to 0.
  - All combinational outputs read 0 while reset is held, including mem_en, the grants and the stalls.
  - Reset mid-access discards the in-flight access: no valid is produced.
  - The first cycle after release can grant.

Test Plan:
1. SYS_reset=0 with if_req=dm_req=1 -> all outputs 0, including mem_en and the stalls. Release reset -> dm_gnt=1 in the first cycle.
2. IF read only: if_addr=0x04 in cycle 0; mem_rdata=0x2010000C in cycle 2 -> if_gnt, mem_en=1, mem_addr=0x04 in cycle 0; if_valid=1, if_rdata=0x2010000C in cycle 3; stall_if=1 in cycles 0-2 and 0 in cycle 3.
3. Conflict: if_addr=0x08 and dm read 0x40 in cycle 0 -> dm_gnt in cycle 0, dm_valid in cycle 3, if_gnt in cycle 3, if_valid in cycle 6, stall_if high in cycles 0-5.
4. DM write: dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF, with if_req high -> cycle 0 has mem_we=1 and mem_wdata=0xDEADBEEF; cycle 1 has dm_valid=1 and if_gnt=1.
5. Starvation with STARVE_MAX=2: dm issues back-to-back writes while if_req is continuously high -> grant sequence DM, DM, IF, DM, DM, IF.
6. Reset mid-read: SYS_reset=0 in cycle 1 of an IF read, released in cycle 2 -> no if_valid ever; if_rdata=0; if_req still high is granted in the first cycle after release.
